// File: rtl/arf096b256e1r1w0cbbeheaa4acw_wr_arb_pkg.sv
// Shared constants, types and helpers for the 96x256 register-file write arbiter.
package arf096b256e1r1w0cbbeheaa4acw_wr_arb_pkg;

    localparam int DEPTH  = 96;
    localparam int DWIDTH = 256;
    localparam int AWIDTH = $clog2(DEPTH);

    typedef logic [AWIDTH-1:0] addr_t;
    typedef logic [DWIDTH-1:0] data_t;

    localparam addr_t MAX_ADDR = addr_t'(DEPTH - 1);

    // Next round-robin position after index idx among n requesters.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic logic addr_in_range(input addr_t a);
        return a <= MAX_ADDR;
    endfunction

endpackage

// File: rtl/arf096b256e1r1w0cbbeheaa4acw_rr_arb.sv
// NREQ-wide round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module arf096b256e1r1w0cbbeheaa4acw_rr_arb
    import arf096b256e1r1w0cbbeheaa4acw_wr_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand_idx;
    int            cand;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= NREQ) cand -= NREQ;
                cand_idx = PW'(cand);
                if (!grant_any && valid[cand_idx]) begin
                    grant_any       = 1'b1;
                    grant_idx       = cand_idx;
                    grant[cand_idx] = 1'b1;
                end
            end
        end
        ptr_d = grant_any ? PW'(rr_wrap(int'(grant_idx), NREQ)) : ptr_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/arf096b256e1r1w0cbbeheaa4acw_wr_arb.sv
// Write-port arbiter, one-deep write staging and fixed-latency read sequencer for a 96x256 1R1W array.
// Optional write-to-read bypass: define ARF096B256E1R1W0CBBEHEAA4ACW_WR_ARB_BYPASS_EN.
module arf096b256e1r1w0cbbeheaa4acw_wr_arb
    import arf096b256e1r1w0cbbeheaa4acw_wr_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic                   arr_wen,
    output logic [AWIDTH-1:0]      arr_waddr,
    output logic [DWIDTH-1:0]      arr_wdata,
    input  logic                   rd_en,
    input  logic [AWIDTH-1:0]      rd_addr,
    output logic                   arr_ren,
    output logic [AWIDTH-1:0]      arr_raddr,
    input  logic [DWIDTH-1:0]      arr_rd_data,
    output logic                   rd_valid,
    output logic [DWIDTH-1:0]      rd_data,
    output logic                   err_oob
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    addr_t           sel_addr;
    data_t           sel_data;
    logic            wr_ok, wr_oob, rd_in;

    logic  wen_q, wen_d, err_oob_q, err_oob_d;
    logic  rd_valid_q, rd_valid_d, rd_oob_q, rd_oob_d;
    addr_t waddr_q, waddr_d;
    data_t wdata_q, wdata_d;

    arf096b256e1r1w0cbbeheaa4acw_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign arr_ren   = rd_en & rd_in;
    assign arr_raddr = rd_addr;
    assign arr_wen   = wen_q;
    assign arr_waddr = waddr_q;
    assign arr_wdata = wdata_q;
    assign rd_valid  = rd_valid_q;
    assign err_oob   = err_oob_q;

    always_comb begin
        sel_addr   = req_addr[grant_idx*AWIDTH +: AWIDTH];
        sel_data   = req_data[grant_idx*DWIDTH +: DWIDTH];
        wr_ok      = grant_any & addr_in_range(sel_addr);
        wr_oob     = grant_any & ~addr_in_range(sel_addr);
        rd_in      = addr_in_range(rd_addr);
        // Out-of-range writes are accepted but never reach the array; staged address/data hold.
        wen_d      = wr_ok;
        waddr_d    = wr_ok ? sel_addr : waddr_q;
        wdata_d    = wr_ok ? sel_data : wdata_q;
        rd_valid_d = rd_en;
        rd_oob_d   = rd_en & ~rd_in;
        err_oob_d  = wr_oob | rd_oob_d;
    end

    // NOTE: the wide staging/data registers are reset because their reset value is visible on outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rd_valid_q <= rd_valid_d;
            rd_oob_q   <= rd_oob_d;
            err_oob_q  <= err_oob_d;
        end
    end

`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_WR_ARB_BYPASS_EN
    logic  hit_q, hit_d;
    data_t byp_data_q, byp_data_d;

    // A read hitting the currently staged write sees the array's old contents, so capture the new data.
    always_comb begin
        hit_d      = rd_en & wen_q & (rd_addr == waddr_q);
        byp_data_d = hit_d ? wdata_q : byp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            hit_q      <= hit_d;
            byp_data_q <= byp_data_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_valid_q && hit_q)          rd_data = byp_data_q;
        else if (rd_valid_q && !rd_oob_q) rd_data = arr_rd_data;
    end
`else
    always_comb begin
        rd_data = '0;
        if (rd_valid_q && !rd_oob_q) rd_data = arr_rd_data;
    end
`endif

endmodule

// File: tb/tb_arf096b256e1r1w0cbbeheaa4acw_wr_arb.sv
// Scoreboard bench for the write arbiter: per-cycle expectations queued at drive time, checked next cycle.
module tb_arf096b256e1r1w0cbbeheaa4acw_wr_arb;
    import arf096b256e1r1w0cbbeheaa4acw_wr_arb_pkg::*;

    localparam int NREQ = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*AWIDTH-1:0] req_addr;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic                   arr_wen;
    logic [AWIDTH-1:0]      arr_waddr;
    logic [DWIDTH-1:0]      arr_wdata;
    logic                   rd_en;
    logic [AWIDTH-1:0]      rd_addr;
    logic                   arr_ren;
    logic [AWIDTH-1:0]      arr_raddr;
    logic [DWIDTH-1:0]      arr_rd_data;
    logic                   rd_valid;
    logic [DWIDTH-1:0]      rd_data;
    logic                   err_oob;

    always #5 clk = ~clk;

    arf096b256e1r1w0cbbeheaa4acw_wr_arb #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .arr_wen     (arr_wen),
        .arr_waddr   (arr_waddr),
        .arr_wdata   (arr_wdata),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .arr_ren     (arr_ren),
        .arr_raddr   (arr_raddr),
        .arr_rd_data (arr_rd_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .err_oob     (err_oob)
    );

    // Array model: read samples old contents when a write hits the same entry on the same edge.
    data_t mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        arr_rd_data = '0;
    end
    always @(posedge clk) begin
        if (arr_ren) arr_rd_data <= mem[arr_raddr];
        if (arr_wen) mem[arr_waddr] <= arr_wdata;
    end

    typedef struct {
        logic  wen;
        addr_t addr;
        data_t data;
    } wr_exp_t;

    typedef struct {
        logic  valid;
        logic  chk;
        data_t data;
        logic  err;
    } rd_exp_t;

    wr_exp_t wr_q [$];
    rd_exp_t rd_q [$];
    data_t   ref_mem [DEPTH];
    int      m_ptr;
    addr_t   m_waddr;
    data_t   m_wdata;
    int      tests = 0;
    int      fails = 0;

    task automatic check(input string tag, input data_t obs, input data_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input addr_t a, input data_t d);
        req_addr[i*AWIDTH +: AWIDTH] = a;
        req_data[i*DWIDTH +: DWIDTH] = d;
    endtask

    // One clock: check this cycle's outputs, queue next cycle's expectations, advance past the edge.
    task automatic cycle(input string tag);
        wr_exp_t         cw, nw;
        rd_exp_t         cr, nr;
        logic [NREQ-1:0] exp_rdy;
        int              g;
        addr_t           a;
        logic            in_rng;
        cw = '{wen: 1'b0, addr: '0, data: '0};
        @(negedge clk);
        exp_rdy = '0;
        g       = -1;
        in_rng  = 1'b0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int c = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check({tag, " req_ready"}, data_t'(req_ready), data_t'(exp_rdy));
        if (wr_q.size() > 0) begin
            cw = wr_q.pop_front();
            check({tag, " arr_wen"}, data_t'(arr_wen), data_t'(cw.wen));
            check({tag, " arr_waddr"}, data_t'(arr_waddr), data_t'(cw.addr));
            check({tag, " arr_wdata"}, arr_wdata, cw.data);
        end
        if (rd_q.size() > 0) begin
            cr = rd_q.pop_front();
            check({tag, " rd_valid"}, data_t'(rd_valid), data_t'(cr.valid));
            check({tag, " err_oob"}, data_t'(err_oob), data_t'(cr.err));
            if (cr.chk) check({tag, " rd_data"}, rd_data, cr.data);
        end
        if (rst) begin
            m_ptr   = 0;
            m_waddr = '0;
            m_wdata = '0;
            nw = '{wen: 1'b0, addr: '0, data: '0};
            nr = '{valid: 1'b0, chk: 1'b1, data: '0, err: 1'b0};
        end else begin
            if (g >= 0) begin
                a      = req_addr[g*AWIDTH +: AWIDTH];
                m_ptr  = (g + 1) % NREQ;
                in_rng = int'(a) < DEPTH;
                if (in_rng) begin
                    m_waddr = a;
                    m_wdata = req_data[g*DWIDTH +: DWIDTH];
                end
            end
            nw.wen    = (g >= 0) && in_rng;
            nw.addr   = m_waddr;
            nw.data   = m_wdata;
            nr.valid  = rd_en;
            nr.chk    = rd_en;
            nr.err    = ((g >= 0) && !in_rng) || (rd_en && int'(rd_addr) >= DEPTH);
            nr.data   = '0;
            if (rd_en && int'(rd_addr) < DEPTH) begin
                nr.data = ref_mem[rd_addr];
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_WR_ARB_BYPASS_EN
                if (cw.wen && cw.addr == rd_addr) nr.data = cw.data;
`endif
            end
        end
        if (cw.wen) ref_mem[cw.addr] = cw.data;
        wr_q.push_back(nw);
        rd_q.push_back(nr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_ptr     = 0;
        m_waddr   = '0;
        m_wdata   = '0;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;

        cycle("rst0");
        cycle("rst1");
        rst = 1'b0;
        cycle("reset_state");

        // All requesters continuously valid: grants rotate 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++)
            set_req(i, addr_t'(i*10 + 1), {8{32'hA000_0000 + 32'(i)}});
        req_valid = '1;
        repeat (5) cycle("rr");
        req_valid = '0;
        cycle("rr_drain");

        // Lone requester 2 writes the last entry, read back two cycles later.
        set_req(2, addr_t'(95), '1);
        req_valid = 4'b0100;
        cycle("w95");
        req_valid = '0;
        cycle("w95_stage");
        rd_en   = 1'b1;
        rd_addr = addr_t'(95);
        cycle("r95");
        rd_en = 1'b0;
        cycle("r95_data");

        // Out-of-range write, then out-of-range read, then both together.
        set_req(1, addr_t'(100), {8{32'hDEAD_BEEF}});
        req_valid = 4'b0010;
        cycle("woob");
        req_valid = '0;
        rd_en     = 1'b1;
        rd_addr   = addr_t'(127);
        cycle("roob");
        rd_en = 1'b0;
        cycle("roob_data");
        req_valid = 4'b0010;
        rd_en     = 1'b1;
        cycle("both_oob");
        req_valid = '0;
        rd_en     = 1'b0;
        cycle("both_oob_err");
        cycle("oob_quiet");

        // Collision: array holds B at 5 while a staged write of A to 5 meets a read of 5.
        set_req(0, addr_t'(5), {8{32'hBBBB_0005}});
        req_valid = 4'b0001;
        cycle("col_b");
        req_valid = '0;
        cycle("col_b_stage");
        cycle("col_b_done");
        set_req(0, addr_t'(5), {8{32'hAAAA_0005}});
        req_valid = 4'b0001;
        cycle("col_a");
        req_valid = '0;
        rd_en     = 1'b1;
        rd_addr   = addr_t'(5);
        cycle("col_rd");
        rd_en = 1'b0;
        cycle("col_data");

        // Reset right after a grant, with a read issued during reset.
        req_valid = '1;
        cycle("pre_rst");
        rst     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = addr_t'(5);
        cycle("mid_rst");
        check("ptr_after_rst", data_t'(dut.u_arb.ptr_q), '0);
        rst       = 1'b0;
        rd_en     = 1'b0;
        req_valid = 4'b1010;
        cycle("post_rst");
        req_valid = '0;
        cycle("post_rst2");
        cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
